// File: rtl/count_ctrl.sv
// Run controller for an external up-counter: loads a start value, paces
// increments through a prescaler, and reports completion at a limit value.
module count_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] preload,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_v,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] snapshot
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] PRESCALE_M1 = 8'(PRESCALE - 1);

  state_t           r_state;
  logic [7:0]       r_presc;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_cnt_v;
  logic [WIDTH-1:0] r_snap;
  logic             r_cnt_rst;
  logic             r_first;

  logic w_presc_wrap;
  logic w_at_limit;
  logic w_step;

  assign w_presc_wrap = (r_presc == PRESCALE_M1);
  assign w_at_limit   = (count == r_lim);
  assign w_step       = (r_state == S_RUN) && w_presc_wrap && !pause && !w_at_limit;

  assign cnt_en   = w_step && !rst;
  assign cnt_rst  = r_cnt_rst || rst;
  assign busy     = (r_state != S_IDLE) && !rst;
  assign done     = (r_state == S_DONE) && !rst;
  assign cnt_v    = r_cnt_v;
  assign snapshot = r_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_lim     <= '0;
      r_cnt_v   <= '0;
      r_snap    <= '0;
      r_cnt_rst <= 1'b1;
      r_first   <= 1'b0;
    end else begin
      r_cnt_rst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt_v   <= preload;
            r_lim     <= limit;
            r_cnt_rst <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_presc <= '0;
          r_first <= 1'b1;
          r_state <= abort ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          r_first <= 1'b0;
          // Completion is qualified from the second RUN cycle on, so a
          // zero-length run reports done two cycles after entering RUN.
          if (abort) begin
            r_state <= S_IDLE;
          end else if (!r_first && w_at_limit) begin
            r_snap  <= count;
            r_state <= S_DONE;
          end else if (!pause) begin
            r_presc <= w_presc_wrap ? 8'd0 : r_presc + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
